// File: rtl/image_pkg.sv
// Shared types and defaults for the image loader and its address counter.
package image_pkg;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 12;

    localparam int unsigned          DEF_IMG_W     = 64;
    localparam int unsigned          DEF_IMG_H     = 64;
    localparam logic [ADDR_W-1:0]    DEF_BASE_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/img_addr_counter.sv
// Raster row/column tracker with an incrementally formed byte address.
module img_addr_counter
    import image_pkg::*;
#(
    parameter int unsigned       IMG_W     = DEF_IMG_W,
    parameter int unsigned       IMG_H     = DEF_IMG_H,
    parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              adv,
    output logic [ADDR_W-1:0] addr,
    output logic              last_c
);

    localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(IMG_H - 1);

    logic [CNT_W-1:0]  col_q, col_d;
    logic [CNT_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    assign addr   = addr_q;
    assign last_c = (col_q == COL_MAX) && (row_q == ROW_MAX);

    // Next position: clear to pixel (0,0) or step one pixel in raster order.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (clr) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = BASE_ADDR;
        end else if (adv) begin
            addr_d = addr_q + ADDR_W'(1);
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= BASE_ADDR;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/image_loader.sv
// Streams a raster image from a valid/ready source into byte-wide data memory
// while holding the processor off.
module image_loader
    import image_pkg::*;
#(
    parameter int unsigned       IMG_W     = DEF_IMG_W,
    parameter int unsigned       IMG_H     = DEF_IMG_H,
    parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [PIX_W-1:0]  s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_din,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done
);

    state_e             state_q, state_d;
    logic               s_ready_q, s_ready_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [PIX_W-1:0]   mem_din_q, mem_din_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               xfer_c;
    logic               cnt_clr_c;
    logic               cnt_last_c;
    logic [ADDR_W-1:0]  cnt_addr;

    // s_ready_q is high exactly while in LOAD, so this is the handshake.
    assign xfer_c    = (state_q == ST_LOAD) && s_valid;
    assign cnt_clr_c = (state_q == ST_IDLE) && start;

    img_addr_counter #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .BASE_ADDR (BASE_ADDR)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr_c),
        .adv    (xfer_c),
        .addr   (cnt_addr),
        .last_c (cnt_last_c)
    );

    // Next state, write pipeline stage and state-decoded outputs.
    always_comb begin
        state_d    = state_q;
        cpu_hold_d = cpu_hold_q;
        mem_we_d   = xfer_c;
        mem_addr_d = xfer_c ? cnt_addr : mem_addr_q;
        mem_din_d  = xfer_c ? s_data   : mem_din_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    cpu_hold_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (xfer_c && cnt_last_c) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d    = ST_DONE;
                cpu_hold_d = 1'b0;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        s_ready_d = (state_d == ST_LOAD);
        busy_d    = (state_d == ST_LOAD) || (state_d == ST_FLUSH);
        done_d    = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            s_ready_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= BASE_ADDR;
            mem_din_q  <= '0;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_ready_q  <= s_ready_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            cpu_hold_q <= cpu_hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign s_ready  = s_ready_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign cpu_hold = cpu_hold_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 Parameter IMG_W, default 64: pixels per image row, range 1..4096.
REQ-002 Parameter IMG_H, default 64: image rows, range 1..4096.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000: data-memory byte address of pixel (0,0).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 start  input  1  load request; sampled only in IDLE.
REQ-007 s_valid  input  1  source byte valid.
REQ-008 s_data  input  8  source pixel byte, raster order.
REQ-009 s_ready  output  1  loader accepts byte.
REQ-010 mem_we  output  1  data-memory byte write enable.
REQ-011 mem_addr  output  32  data-memory byte address.
REQ-012 mem_din  output  8  data-memory write byte.
REQ-013 cpu_hold  output  1  holds processor fetch/PC while high.
REQ-014 busy  output  1  high in LOAD or FLUSH.
REQ-015 done  output  1  one-cycle pulse at load completion.

Function
REQ-016 The block SHALL implement states IDLE, LOAD, FLUSH, DONE.
REQ-017 IDLE: s_ready=0; start=1 -> LOAD next cycle; col=0, row=0, cpu_hold=1.
REQ-018 LOAD: s_ready=1 combinationally from state only, never dependent on s_valid.
REQ-019 Handshake: a byte transfers in a cycle where s_valid=1 and s_ready=1; no transfer otherwise; s_valid low cycles stall the counters.
REQ-020 Write latency SHALL be one cycle: transfer at cycle N -> mem_we=1, mem_din=byte, mem_addr=BASE_ADDR+row*IMG_W+col at cycle N+1; mem_we=0 in every other cycle.
REQ-021 The address SHALL be formed incrementally (+1 per transfer); no multiplier.
REQ-022 col increments per transfer; at col=IMG_W-1 col wraps to 0 and row increments.
REQ-023 Transfer with row=IMG_H-1 and col=IMG_W-1 -> FLUSH; s_ready=0 from the following cycle; exactly IMG_W*IMG_H writes per load.
REQ-024 FLUSH: one cycle, in which the last write is issued; then -> DONE.
REQ-025 DONE: done=1 and cpu_hold=0 for one cycle; -> IDLE; cpu_hold stays 0 in IDLE until the next start.
REQ-026 start asserted outside IDLE SHALL be ignored, without queuing.
REQ-027 start and s_valid in the same IDLE cycle: no transfer; the first transfer is possible in the first LOAD cycle.
REQ-028 IMG_W=1 or IMG_H=1 SHALL work, with wrap occurring on every transfer or never incrementing row, respectively.

Reset
REQ-029 rst_n low SHALL force, asynchronously, state=IDLE, row=col=0, mem_we=0, mem_addr=BASE_ADDR, mem_din=0, s_ready=0, busy=0, done=0, cpu_hold=1.
REQ-030 Reset mid-LOAD SHALL abandon the image; no write is issued after rst_n falls; a new start restarts at (0,0).
REQ-031 After rst_n rises, outputs remain at their reset values until start.

Structure
REQ-032 Shared package image_pkg SHALL hold the state enum, the default IMG_W/IMG_H/BASE_ADDR constants, and the pixel byte width (8).
REQ-033 One sub-module img_addr_counter (row/col/address with wrap and last-pixel flag) SHALL be instantiated; the FSM and output registers stay in image_loader.

Verification (IMG_W=4, IMG_H=2, BASE_ADDR=32'h100)
REQ-034 Reset, then start, then 8 back-to-back bytes 8'h10..8'h17 -> writes to addresses 0x100..0x107 with matching bytes on consecutive cycles; done pulses once 2 cycles after the last transfer; cpu_hold falls with done.
REQ-035 Same stream with s_valid low every other cycle -> same 8 writes in order, no gaps in address, no duplicate writes, and mem_we only in cycles following a transfer.
REQ-036 start pulsed during LOAD after 3 bytes -> ignored; total writes=8; exactly one done pulse.
REQ-037 rst_n pulsed low after 5 transfers -> mem_we=0 immediately; cpu_hold=1; restart with 8 bytes 8'hA0..8'hA7 -> writes start at 0x100.
REQ-038 start and s_valid=1 with s_data=8'hFF in the same IDLE cycle -> no write of 8'hFF from that cycle; the first write occurs only after a LOAD-cycle transfer.
REQ-039 Boundary check: byte 4 (8'h14) SHALL be written to 0x104 with row=1, col=0, and the last byte (8'h17) to 0x107; s_ready=0 in the cycle after the last transfer.
